// File: rtl/imem_pkg.sv
// imem_pkg: instruction width, NOP encoding and FSM state type shared by the imem responder files
package imem_pkg;
  localparam int INST_WIDTH = 32;
  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_t;
endpackage

// File: rtl/imem_fetch_responder_array.sv
// imem_array: MEM_SIZE x 32 word store (ports: clk, we/waddr/wdata sync write, raddr -> rdata async read)
module imem_array
  import imem_pkg::*;
#(
  parameter int MEM_SIZE = 256,
  parameter int IW = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IW-1:0]         waddr,
  input  logic [INST_WIDTH-1:0] wdata,
  input  logic [IW-1:0]         raddr,
  output logic [INST_WIDTH-1:0] rdata
);
  logic [INST_WIDTH-1:0] mem [MEM_SIZE];
  assign rdata = mem[raddr];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
endmodule

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: fetch responder (clk/rst; req_valid/req_ready/req_addr/flush in; rsp_valid/rsp_ready/rsp_inst/rsp_fault out; load_en/load_addr/load_data fill port)
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_SIZE = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic                     flush,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [INST_WIDTH-1:0]    rsp_inst,
  output logic                     rsp_fault,
  input  logic                     load_en,
  input  logic [ADDRESS_WIDTH-1:0] load_addr,
  input  logic [INST_WIDTH-1:0]    load_data
);
  localparam int IW = MEM_SIZE > 1 ? $clog2(MEM_SIZE) : 1;
  imem_state_t state, state_n;
  logic [3:0] cnt;
  logic [ADDRESS_WIDTH-1:0] addr_q, rd_addr;
  logic [INST_WIDTH-1:0] rd_data;
  logic accept, fault, enter_resp, load_ok;
  assign req_ready = !flush && (state == IDLE || (state == RESP && rsp_ready));
  assign accept = req_valid && req_ready;
  assign rsp_valid = state == RESP;
  assign rd_addr = accept ? req_addr : addr_q;
  assign fault = (rd_addr[1:0] != 2'b00) || ((rd_addr >> 2) >= ADDRESS_WIDTH'(MEM_SIZE));
  assign load_ok = (load_addr >> 2) < ADDRESS_WIDTH'(MEM_SIZE);
  assign enter_resp = state_n == RESP && (state != RESP || accept);
  always_comb begin
    state_n = flush ? IDLE :
              accept ? (WAIT_CYCLES == 0 ? RESP : WAIT) :
              (state == WAIT && cnt == 4'd1) ? RESP :
              (state == RESP && rsp_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      rsp_inst <= '0;
      rsp_fault <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= accept ? 4'(WAIT_CYCLES) : state == WAIT ? cnt - 4'd1 : cnt;
      if (accept) addr_q <= req_addr;
      if (enter_resp) begin
        rsp_inst <= fault ? NOP_INST : rd_data;
        rsp_fault <= fault;
      end
    end
  end
  imem_array #(.MEM_SIZE(MEM_SIZE), .IW(IW)) u_array (
    .clk(clk),
    .we(load_en && load_ok),
    .waddr(load_addr[IW+1:2]),
    .wdata(load_data),
    .raddr(rd_addr[IW+1:2]),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb_imem_fetch_responder: directed scoreboard bench over WAIT_CYCLES = 0, 3 and 2 instances
module tb_imem_fetch_responder;
  import imem_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1, req_valid = 1'b0, flush = 1'b0, rsp_ready = 1'b0, load_en = 1'b0;
  logic [31:0] req_addr = '0, load_addr = '0, load_data = '0;
  logic rdy_a [3], vld_a [3], flt_a [3];
  logic [31:0] inst_a [3];
  logic rdy, vld, flt;
  logic [31:0] inst;
  logic [31:0] ref_mem [256];
  logic [32:0] sb [$];
  int sel = 0, tests = 0, fails = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    imem_fetch_responder #(.ADDRESS_WIDTH(32), .MEM_SIZE(256), .WAIT_CYCLES(g == 0 ? 0 : g == 1 ? 3 : 2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_a[g]), .req_addr(req_addr),
      .flush(flush), .rsp_valid(vld_a[g]), .rsp_ready(rsp_ready), .rsp_inst(inst_a[g]),
      .rsp_fault(flt_a[g]), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );
  end
  always_comb begin
    rdy = rdy_a[sel];
    vld = vld_a[sel];
    flt = flt_a[sel];
    inst = inst_a[sel];
  end
  function automatic logic [32:0] expv(input logic [31:0] a);
    logic f;
    f = a[1:0] != 2'b00 || (a >> 2) >= 32'd256;
    return {f, f ? NOP_INST : ref_mem[a[9:2]]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic [32:0] e;
    #1;
    if (vld && rsp_ready) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL sb_empty: observed response %h expected none", inst);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_inst", inst, e[31:0]);
        chk("rsp_fault", 32'(flt), 32'(e[32]));
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [31:0] a, input bit track);
    req_valid = 1'b1;
    req_addr = a;
    if (track) sb.push_back(expv(a));
    #1 chk("req_ready", 32'(rdy), 32'd1);
  endtask
  task automatic ld(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
    if ((a >> 2) < 32'd256) ref_mem[a[9:2]] = d;
  endtask
  task automatic drain(input int max);
    for (int i = 0; i < max && sb.size() != 0; i++) tick();
    chk("drain", 32'(sb.size()), 32'd0);
  endtask
  task automatic reset_all();
    rst = 1'b1;
    req_valid = 1'b0;
    flush = 1'b0;
    rsp_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tick();
    tick();
    chk("reset_valid", 32'(vld), 32'd0);
    chk("reset_inst", inst, 32'd0);
    chk("reset_fault", 32'(flt), 32'd0);
    chk("reset_ready", 32'(rdy), 32'd1);
    ld(32'h0, 32'h0000_0011);
    ld(32'h4, 32'h0000_0093);
    ld(32'h8, 32'h0010_0113);
    ld(32'h3FC, 32'hCAFE_0001);
    ld(32'h400, 32'h1234_5678);
    rst = 1'b0;
    sel = 0;
    rsp_ready = 1'b1;
    put(32'h4, 1'b1);
    tick();
    chk("lat0_valid", 32'(vld), 32'd1);
    put(32'h8, 1'b1);
    tick();
    chk("b2b_valid", 32'(vld), 32'd1);
    put(32'h6, 1'b1);
    tick();
    put(32'h400, 1'b1);
    tick();
    put(32'h3FC, 1'b1);
    tick();
    put(32'h0, 1'b1);
    tick();
    req_valid = 1'b0;
    drain(4);
    chk("idle_valid", 32'(vld), 32'd0);
    sel = 1;
    reset_all();
    put(32'h4, 1'b1);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_valid", 32'(vld), 32'd0);
      chk("wait_ready", 32'(rdy), 32'd0);
      tick();
    end
    chk("wait3_valid", 32'(vld), 32'd1);
    req_valid = 1'b1;
    req_addr = 32'h8;
    for (int i = 0; i < 4; i++) begin
      chk("stall_inst", inst, 32'h0000_0093);
      chk("stall_valid", 32'(vld), 32'd1);
      chk("stall_ready", 32'(rdy), 32'd0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("stall_done", 32'(vld), 32'd0);
    drain(1);
    sel = 2;
    reset_all();
    rsp_ready = 1'b1;
    put(32'h4, 1'b0);
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    #1 chk("flush_ready", 32'(rdy), 32'd0);
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("flush_drop", 32'(vld), 32'd0);
      tick();
    end
    flush = 1'b1;
    req_valid = 1'b1;
    req_addr = 32'h8;
    #1 chk("flush_idle_ready", 32'(rdy), 32'd0);
    tick();
    flush = 1'b0;
    put(32'h8, 1'b1);
    tick();
    req_valid = 1'b0;
    drain(6);
    put(32'h4, 1'b1);
    tick();
    req_valid = 1'b0;
    tick();
    load_en = 1'b1;
    load_addr = 32'h4;
    load_data = 32'hDEAD_BEEF;
    tick();
    load_en = 1'b0;
    ref_mem[1] = 32'hDEAD_BEEF;
    chk("rbw_valid", 32'(vld), 32'd1);
    drain(4);
    put(32'h4, 1'b1);
    tick();
    req_valid = 1'b0;
    drain(6);
    rsp_ready = 1'b0;
    put(32'h4, 1'b0);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_valid", 32'(vld), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(vld), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_fault", 32'(flt), 32'd0);
    chk("rst_ready", 32'(rdy), 32'd1);
    rsp_ready = 1'b1;
    put(32'h4, 1'b1);
    tick();
    req_valid = 1'b0;
    drain(6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Instruction-memory responder at the far end of the fetch interface. The PC/fetch stage issues an instruction address; this block returns the 32-bit instruction word.
- Supports a configurable number of wait states and a single outstanding request.
- Flags misaligned and out-of-range addresses as faults.
- Provides a load port through which the bench or boot logic fills the memory.

Parameters:
- ADDRESS_WIDTH, 32: width of the byte address.
- MEM_SIZE, 256: number of 32-bit words stored.
- WAIT_CYCLES, 0: extra cycles between request acceptance and response; range 0..15.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  1  fetch request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_addr  input  ADDRESS_WIDTH  byte address of the instruction.
- flush  input  1  discard any outstanding request (branch/redirect).
- rsp_valid  output  1  response word valid.
- rsp_ready  input  1  fetch stage consumes the response.
- rsp_inst  output  32  instruction word.
- rsp_fault  output  1  the request was misaligned or out of range.
- load_en  input  1  write one word into memory.
- load_addr  input  ADDRESS_WIDTH  byte address of the load; bits [1:0] are ignored.
- load_data  input  32  word to store.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, rsp_valid=0, rsp_inst=0, rsp_fault=0, wait counter=0. Memory contents are not cleared.
- FSM has three states: IDLE, WAIT, RESP.
- req_ready = !flush && (state==IDLE || (state==RESP && rsp_ready)). This is combinational from rsp_ready and flush, and allows back-to-back fetches.
- Request accept (req_valid && req_ready):
  - Register the address.
  - Compute fault = (addr[1:0]!=0) || (addr>>2 >= MEM_SIZE).
  - If WAIT_CYCLES==0, go to RESP. Otherwise go to WAIT with counter=WAIT_CYCLES.
- WAIT:
  - Counter decrements each cycle.
  - When counter==1, go to RESP next cycle.
- Latency: a request accepted at edge N gives rsp_valid=1 after edge N+1+WAIT_CYCLES.
- Data capture: rsp_inst and rsp_fault are registered on the edge that enters RESP.
  - On fault, rsp_inst=NOP (32'h0000_0013) and rsp_fault=1.
  - A load to the same word on that same edge returns the old data (read-before-write).
- RESP:
  - rsp_valid=1; rsp_inst and rsp_fault stay stable until rsp_ready.
  - On rsp_ready with no new request, go to IDLE and drop rsp_valid.
  - On rsp_ready with a simultaneous new request, follow the request-accept rules.
- Flush:
  - From WAIT or RESP, go to IDLE on the next edge; rsp_valid=0 after that edge and the pending word is dropped.
  - Flush overrides a simultaneous rsp_ready or request: the request is not accepted.
  - In IDLE, flush only blocks acceptance.
- Load port:
  - Writes in any state, including during reset.
  - Out-of-range load_addr (word index >= MEM_SIZE) is ignored.
- Reset mid-WAIT or mid-RESP: the outstanding request is lost and the FSM returns to IDLE; memory is kept.

Decomposition:
- Package imem_pkg holds:
  - INST_WIDTH=32.
  - NOP_INST=32'h0000_0013.
  - The state enum imem_state_t {IDLE, WAIT, RESP}.
- Sub-module imem_array: MEM_SIZE x 32 storage with one synchronous write port and one read port (registered by the responder). It is the only storage in the block.

Test Plan:
- WAIT_CYCLES=0: load word 1=32'h0000_0093 and word 2=32'h0010_0113; request 0x4 with rsp_ready=1 -> rsp_valid after 1 edge with inst 0x00000093 and fault 0. Then request 0x8 back-to-back -> one response per cycle, no bubble.
- WAIT_CYCLES=3: request 0x4 at edge N, hold rsp_ready=0 for 4 cycles -> rsp_valid rises after edge N+4. rsp_inst stays 0x00000093 while stalled; req_ready=0 throughout.
- Fault cases: request 0x6 -> rsp_inst=0x00000013, fault=1. Request 4*MEM_SIZE=0x400 -> fault=1. Request 0x3FC -> valid word, fault=0.
- Flush: WAIT_CYCLES=2; accept 0x4, assert flush one cycle later -> no rsp_valid ever for that request. The next request 0x8 returns 0x00100113.
- Load/read same edge: load word 1=0xDEADBEEF on the edge entering RESP for 0x4 -> returns old 0x00000093. A repeat fetch returns 0xDEADBEEF.
- Reset mid-RESP with rsp_valid=1 -> next edge rsp_valid=0, rsp_inst=0, req_ready=1. Memory word 1 still reads 0xDEADBEEF.
